// File: rtl/basic_logic_gates.sv
// basic_logic_gates: registered bitwise logic unit.
// Computes AND, OR and NOT(A) over two WIDTH-bit operands. Results load one
// cycle after a valid strobe and hold while in_valid is low; out_valid pulses
// once per accepted operand pair.
// Optional macro BASIC_LOGIC_GATES_EXT_EN adds registered NAND, NOR, XOR and
// XNOR outputs with identical enable, hold, latency and reset behaviour.
// Reset is synchronous, active-high, and wins over in_valid on the same edge.

module basic_logic_gates #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
`ifdef BASIC_LOGIC_GATES_EXT_EN
  output logic [WIDTH-1:0] y_nand,
  output logic [WIDTH-1:0] y_nor,
  output logic [WIDTH-1:0] y_xor,
  output logic [WIDTH-1:0] y_xnor,
`endif
  output logic [WIDTH-1:0] y_not
);

  localparam logic [WIDTH-1:0] AllZeros = '0;
  localparam logic [WIDTH-1:0] AllOnes  = '1;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] and_d,   and_q;
  logic [WIDTH-1:0] or_d,    or_q;
  logic [WIDTH-1:0] not_d,   not_q;

`ifdef BASIC_LOGIC_GATES_EXT_EN
  logic [WIDTH-1:0] nand_d,  nand_q;
  logic [WIDTH-1:0] nor_d,   nor_q;
  logic [WIDTH-1:0] xor_d,   xor_q;
  logic [WIDTH-1:0] xnor_d,  xnor_q;
`endif

  // Next-state: load fresh results on a valid strobe, otherwise hold.
  always_comb begin
    valid_d = in_valid;
    and_d   = and_q;
    or_d    = or_q;
    not_d   = not_q;
`ifdef BASIC_LOGIC_GATES_EXT_EN
    nand_d  = nand_q;
    nor_d   = nor_q;
    xor_d   = xor_q;
    xnor_d  = xnor_q;
`endif
    if (in_valid) begin
      and_d  = a & b;
      or_d   = a | b;
      not_d  = ~a;
`ifdef BASIC_LOGIC_GATES_EXT_EN
      nand_d = ~(a & b);
      nor_d  = ~(a | b);
      xor_d  = a ^ b;
      xnor_d = ~(a ^ b);
`endif
    end
  end

  // State registers; reset values equal each gate applied to all-zero operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      and_q   <= AllZeros;
      or_q    <= AllZeros;
      not_q   <= AllOnes;
`ifdef BASIC_LOGIC_GATES_EXT_EN
      nand_q  <= AllOnes;
      nor_q   <= AllOnes;
      xor_q   <= AllZeros;
      xnor_q  <= AllOnes;
`endif
    end else begin
      valid_q <= valid_d;
      and_q   <= and_d;
      or_q    <= or_d;
      not_q   <= not_d;
`ifdef BASIC_LOGIC_GATES_EXT_EN
      nand_q  <= nand_d;
      nor_q   <= nor_d;
      xor_q   <= xor_d;
      xnor_q  <= xnor_d;
`endif
    end
  end

  // Outputs come straight from registers; no input-to-output path.
  always_comb begin
    out_valid = valid_q;
    y_and     = and_q;
    y_or      = or_q;
    y_not     = not_q;
`ifdef BASIC_LOGIC_GATES_EXT_EN
    y_nand    = nand_q;
    y_nor     = nor_q;
    y_xor     = xor_q;
    y_xnor    = xnor_q;
`endif
  end

endmodule

// File: tb/tb_basic_logic_gates.sv
// Bench for basic_logic_gates: a WIDTH=1 and a WIDTH=8 instance share clock and
// reset. A truth-table reference model predicts every registered output.

module tb_basic_logic_gates;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;

  logic       v1, v8;
  logic [0:0] y1_and, y1_or, y1_not;
  logic [7:0] y8_and, y8_or, y8_not;
`ifdef BASIC_LOGIC_GATES_EXT_EN
  logic [0:0] y1_nand, y1_nor, y1_xor, y1_xnor;
  logic [7:0] y8_nand, y8_nor, y8_xor, y8_xnor;
`endif

  always #5 clk = ~clk;

  basic_logic_gates #(.WIDTH(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a1),
    .b        (b1),
    .out_valid(v1),
    .y_and    (y1_and),
    .y_or     (y1_or),
`ifdef BASIC_LOGIC_GATES_EXT_EN
    .y_nand   (y1_nand),
    .y_nor    (y1_nor),
    .y_xor    (y1_xor),
    .y_xnor   (y1_xnor),
`endif
    .y_not    (y1_not)
  );

  basic_logic_gates #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a8),
    .b        (b8),
    .out_valid(v8),
    .y_and    (y8_and),
    .y_or     (y8_or),
`ifdef BASIC_LOGIC_GATES_EXT_EN
    .y_nand   (y8_nand),
    .y_nor    (y8_nor),
    .y_xor    (y8_xor),
    .y_xnor   (y8_xnor),
`endif
    .y_not    (y8_not)
  );

  // Gate truth tables indexed by {a,b}: and, or, not(a), nand, nor, xor, xnor.
  logic [3:0] tt [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          step_n = 0;

  logic [7:0] e8 [7];
  logic       ev;

  function automatic logic [7:0] gate(int op, logic [7:0] x, logic [7:0] y);
    logic [7:0] r;
    logic [3:0] t;
    t = tt[op];
    for (int i = 0; i < 8; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s step%0d observed=%h expected=%h", tag, step_n, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check both instances.
  task automatic step(input logic r, input logic v, input logic [7:0] av, input logic [7:0] bv);
    rst      = r;
    in_valid = v;
    a8       = av;
    b8       = bv;
    a1       = av[0];
    b1       = bv[0];
    @(posedge clk);
    #1;
    step_n++;
    if (r) begin
      for (int op = 0; op < 7; op++) e8[op] = gate(op, 8'h00, 8'h00);
      ev = 1'b0;
    end else if (v) begin
      for (int op = 0; op < 7; op++) e8[op] = gate(op, av, bv);
      ev = 1'b1;
    end else begin
      ev = 1'b0;
    end
    chk("valid1", {7'b0, v1}, {7'b0, ev});
    chk("valid8", {7'b0, v8}, {7'b0, ev});
    chk("and1", {7'b0, y1_and}, {7'b0, e8[0][0]});
    chk("or1",  {7'b0, y1_or},  {7'b0, e8[1][0]});
    chk("not1", {7'b0, y1_not}, {7'b0, e8[2][0]});
    chk("and8", y8_and, e8[0]);
    chk("or8",  y8_or,  e8[1]);
    chk("not8", y8_not, e8[2]);
`ifdef BASIC_LOGIC_GATES_EXT_EN
    chk("nand1", {7'b0, y1_nand}, {7'b0, e8[3][0]});
    chk("nor1",  {7'b0, y1_nor},  {7'b0, e8[4][0]});
    chk("xor1",  {7'b0, y1_xor},  {7'b0, e8[5][0]});
    chk("xnor1", {7'b0, y1_xnor}, {7'b0, e8[6][0]});
    chk("nand8", y8_nand, e8[3]);
    chk("nor8",  y8_nor,  e8[4]);
    chk("xor8",  y8_xor,  e8[5]);
    chk("xnor8", y8_xnor, e8[6]);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    for (int op = 0; op < 7; op++) e8[op] = '0;
    ev = 1'b0;

    // Reset state.
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    chk("rst_not8_const", y8_not, 8'hFF);

    // One-bit truth table, one pair per cycle.
    step(1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h01);
    step(1'b0, 1'b1, 8'h01, 8'h00);
    step(1'b0, 1'b1, 8'h01, 8'h01);
    chk("tt11_and1_const", {7'b0, y1_and}, 8'h01);

    // Reset beats in_valid for two cycles, then first result after release.
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'hFF);

    // Hold while in_valid is low and operands change.
    step(1'b0, 1'b1, 8'h01, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h01);
    chk("hold_or1_const", {7'b0, y1_or}, 8'h01);

    // Mixed byte pattern against literal results.
    step(1'b0, 1'b1, 8'hF0, 8'hCC);
    chk("f0cc_and8", y8_and, 8'hC0);
    chk("f0cc_or8",  y8_or,  8'hFC);
    chk("f0cc_not8", y8_not, 8'h0F);
`ifdef BASIC_LOGIC_GATES_EXT_EN
    chk("f0cc_nand8", y8_nand, 8'h3F);
    chk("f0cc_nor8",  y8_nor,  8'h03);
    chk("f0cc_xor8",  y8_xor,  8'h3C);
    chk("f0cc_xnor8", y8_xnor, 8'hC3);
`endif

    // Reset mid-stream with valid all-ones operands.
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    chk("mid_rst_and8", y8_and, 8'h00);
    chk("mid_rst_not8", y8_not, 8'hFF);
    chk("mid_rst_valid8", {7'b0, v8}, 8'h00);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
           8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/basic_logic_gates.md
# basic_logic_gates

Registered bitwise logic unit computing AND, OR and NOT(A) over two operand vectors. Serves as the team's reference combinational-to-registered gate block. Used wherever a clean, reset-defined logic result is needed one cycle after operands are presented. Operands are qualified by a valid strobe, and results hold between valid updates.

## Interface
- WIDTH, 1, operand and result width in bits (legal range 1–64)
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; sampled on rising edge of clk
- in_valid  input  1  operands a/b are valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  results updated on this cycle's edge (one-cycle pulse per accepted input)
- y_and  output  WIDTH  registered a & b
- y_or  output  WIDTH  registered a | b
- y_not  output  WIDTH  registered ~a (b ignored)
- y_nand, y_nor, y_xor, y_xnor  output  WIDTH  present only with BASIC_LOGIC_GATES_EXT_EN (see Configuration)

## Operation
- Per bit i, independent of every other bit:
  - y_and[i] = a[i] & b[i]
  - y_or[i] = a[i] | b[i]
  - y_not[i] = ~a[i]
- No carries and no cross-bit interaction; all results exactly WIDTH bits.
- Truth table for one bit (A B -> AND OR NOT(A)):
  - 0 0 -> 0 0 1
  - 0 1 -> 0 1 1
  - 1 0 -> 0 1 0
  - 1 1 -> 1 1 0
- On a rising edge with in_valid=1 and rst=0: all result registers load the new values and out_valid is set to 1.
- On a rising edge with in_valid=0 and rst=0: result registers hold their previous value and out_valid is set to 0.
- Inputs are never X-propagated by design intent. Behaviour with X on a/b follows plain bitwise semantics.
- No backpressure: every in_valid cycle is accepted.

## Timing
- Latency: exactly 1 clk cycle from in_valid sample to out_valid/result update. Throughput: one result per cycle.
- Reset (rst=1 at a rising edge) sets:
  - out_valid = 0
  - y_and = 0, y_or = 0
  - y_not = all ones, i.e. NOT of a reset-zero A; nand/xnor likewise all ones
  - y_nor = all ones, y_xor = 0
- rst has priority over in_valid on the same edge; the operands presented that cycle are discarded.
- Reset asserted mid-stream clears results on the next edge. The first valid after rst deasserts produces out_valid one cycle later.
- Outputs change only on clk rising edges; no combinational path from any input to any output.

## Configuration
- Macro BASIC_LOGIC_GATES_EXT_EN.
- Defined: adds registered outputs y_nand = ~(a&b), y_nor = ~(a|b), y_xor = a^b, y_xnor = ~(a^b).
  - Same enable, hold, latency and reset rules as the base outputs.
  - Reset values: y_nand = all ones, y_nor = all ones, y_xor = 0, y_xnor = all ones.
- Undefined: these four ports and their registers do not exist. The base outputs are unchanged.

## Test plan
- WIDTH=1; apply a/b = 00, 01, 10, 11 with in_valid=1, one per cycle -> one cycle later:
  - y_and = 0,0,0,1
  - y_or = 0,1,1,1
  - y_not = 1,1,0,0
  - out_valid = 1 each cycle
- Reset: hold rst=1 for 2 cycles with a=1, b=1, in_valid=1 -> out_valid=0, y_and=0, y_or=0, y_not=1. Release rst -> first results appear next cycle.
- Hold: load a=1, b=0, then drop in_valid and drive a=0, b=1 for 3 cycles -> y_and=0, y_or=1, y_not=0 held; out_valid=0 during the hold.
- WIDTH=8; a=8'hF0, b=8'hCC -> y_and=8'hC0, y_or=8'hFC, y_not=8'h0F. With EXT_EN also: y_nand=8'h3F, y_nor=8'h03, y_xor=8'h3C, y_xnor=8'hC3.
- Reset mid-stream: rst=1 and in_valid=1 on the same edge with a=8'hFF, b=8'hFF -> y_and=0, y_not=8'hFF, out_valid=0.
